// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the HI/LO divide unit: FSM state type and
// the R-type function codes that select div and mfhi.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    localparam logic [5:0] DIV_FUNC  = 6'h1A;
    localparam logic [5:0] MFHI_FUNC = 6'h10;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, try to
// subtract the divisor magnitude, and keep the difference if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH+1:0] trial;
    logic             non_negative;

    always_comb begin
        rem_shifted  = {rem, quo[WIDTH-1]};
        trial        = {1'b0, rem_shifted} - {2'b00, divisor_mag};
        // A successful trial is always below divisor_mag, so bit WIDTH is clear too.
        non_negative = !trial[WIDTH+1] && !trial[WIDTH];
        if (non_negative) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle div/divu unit owning the architectural HI/LO registers; LO gets
// the quotient, HI the remainder, and mf_out serves mfhi/mflo write-back.
module hilo_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ismfhi,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out,
    output div_state_t       state
);

    // Handshake: start is accepted only in IDLE; busy stays high from the
    // accepting edge through the FIXUP cycle; done pulses for one cycle once
    // hi/lo hold the result. start outside IDLE is dropped silently.

    div_state_t       next_state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor_mag_q;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_zero;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign dividend_neg = signed_op & dividend[WIDTH-1];
    assign divisor_neg  = signed_op & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg ? -divisor : divisor;
    assign divisor_zero = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem         (rem),
        .quo         (quo),
        .divisor_mag (divisor_mag_q),
        .rem_next    (rem_next),
        .quo_next    (quo_next)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = divisor_zero ? FIXUP : DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    next_state = FIXUP;
                end
            end
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            quo           <= '0;
            divisor_mag_q <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            hi            <= '0;
            lo            <= '0;
            div_zero      <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q        <= dividend_neg ^ divisor_neg;
                        sign_r        <= dividend_neg;
                        rem           <= '0;
                        cnt           <= '0;
                        divisor_mag_q <= divisor_mag;
                        // On divide-by-zero quo carries the raw dividend straight to HI.
                        quo           <= divisor_zero ? dividend : dividend_mag;
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    if (divisor_mag_q == '0) begin
                        hi       <= quo;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        lo       <= sign_q ? -quo : quo;
                        hi       <= sign_r ? -rem : rem;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == DIVIDE) || (state == FIXUP);
    assign done   = (state == DONE);
    assign mf_out = ismfhi ? hi : lo;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: hand-computed quotients/remainders,
// latency and busy length, divide-by-zero, ignored start and mid-run reset.
module tb_hilo_div_unit;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ismfhi;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;
    div_state_t  state;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    int          lat;
    int          busy_n;
    int          done_n;

    hilo_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .ismfhi    (ismfhi),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .mf_out    (mf_out),
        .state     (state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pops expected lo then hi from the scoreboard and compares.
    task automatic compare_result(input string tag);
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        exp_lo = exp_q.pop_front();
        exp_hi = exp_q.pop_front();
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
    endtask

    // Drives one start pulse, then watches until done. inj_at >= 0 re-pulses
    // start (50/5) at that cycle; rst_at >= 0 asserts reset at that cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int inj_at, input int rst_at,
                           output int lat_o, output int busy_o, output int done_o);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        signed_op = sgn;
        start     = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat_o  = 0;
        busy_o = 0;
        done_o = 0;
        while (lat_o < 100) begin
            if (busy) busy_o++;
            if (done) begin
                done_o++;
                break;
            end
            if (lat_o == inj_at) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (lat_o == rst_at) begin
                start = 1'b0;
                reset = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_hi", hi, 32'd0);
                check("rst_lo", lo, 32'd0);
                check("rst_state", 32'(state), 32'(IDLE));
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            @(negedge clock);
            lat_o++;
        end
        start = 1'b0;
        check("done_seen", 32'(done_o), 32'd1);
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        check("back_idle", 32'(state), 32'(IDLE));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        ismfhi    = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_state", 32'(state), 32'(IDLE));
        reset = 1'b0;

        // divu 100 / 7
        exp_q.push_back(32'd14); exp_q.push_back(32'd2);
        run_div(32'd100, 32'd7, 1'b0, -1, -1, lat, busy_n, done_n);
        check("divu_latency", 32'(lat), 32'd33);
        check("divu_busy_cycles", 32'(busy_n), 32'd33);
        compare_result("divu_100_7");
        check("divu_dz", 32'(div_zero), 32'd0);

        // div -7 / 2
        exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'hFFFF_FFFF);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, lat, busy_n, done_n);
        compare_result("div_m7_2");
        ismfhi = 1'b0;
        #1 check("mflo", mf_out, 32'hFFFF_FFFD);
        ismfhi = 1'b1;
        #1 check("mfhi", mf_out, 32'hFFFF_FFFF);

        // signed overflow, then unsigned max / 1
        exp_q.push_back(32'h8000_0000); exp_q.push_back(32'd0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, lat, busy_n, done_n);
        compare_result("div_ovf");
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd0);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, lat, busy_n, done_n);
        compare_result("divu_max_1");

        // divide by zero, then a normal divide clears the flag
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd1234);
        run_div(32'd1234, 32'd0, 1'b1, -1, -1, lat, busy_n, done_n);
        check("dz_latency", 32'(lat), 32'd1);
        check("dz_busy_cycles", 32'(busy_n), 32'd1);
        compare_result("div_zero");
        check("dz_flag", 32'(div_zero), 32'd1);
        exp_q.push_back(32'd3); exp_q.push_back(32'd0);
        run_div(32'd9, 32'd3, 1'b0, -1, -1, lat, busy_n, done_n);
        compare_result("divu_9_3");
        check("dz_cleared", 32'(div_zero), 32'd0);

        // signed 7 / -2: quotient truncates, remainder follows dividend
        exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'd1);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1, lat, busy_n, done_n);
        compare_result("div_7_m2");

        // start while busy is ignored
        exp_q.push_back(32'd14); exp_q.push_back(32'd2);
        run_div(32'd100, 32'd7, 1'b0, 10, -1, lat, busy_n, done_n);
        check("ign_latency", 32'(lat), 32'd33);
        check("ign_done_count", 32'(done_n), 32'd1);
        compare_result("ignored_start");
        ismfhi = 1'b0;

        // reset mid-division, then a fresh divide
        run_div(32'd1000, 32'd3, 1'b0, -1, 15, lat, busy_n, done_n);
        #1 check("post_rst_mf", mf_out, 32'd0);
        exp_q.push_back(32'd4); exp_q.push_back(32'd1);
        run_div(32'd9, 32'd2, 1'b0, -1, -1, lat, busy_n, done_n);
        compare_result("after_reset_9_2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle divide unit with the architectural HI/LO registers. Sits directly downstream of the ALU control stage in the multi-cycle datapath.
- Consumes the isDiv (func 0x1A, R-type) and ismfhi (func 0x10) decodes. Runs a radix-2 restoring division on the rs/rt operands, writes the quotient to LO and the remainder to HI.
- Drives busy back to the main control FSM so it holds in the execute state until done.
- Returns HI or LO for mfhi/mflo write-back.

Parameters:
- WIDTH, 32, operand / HI / LO width.
- CNT_W, 5, iteration counter width; ceil(log2(WIDTH)).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  isDiv qualified by the control FSM execute state; one-cycle pulse expected.
- signed_op  in  1  1 = div (two's complement), 0 = divu.
- dividend  in  WIDTH  rs value; sampled only on an accepted start.
- divisor  in  WIDTH  rt value; sampled only on an accepted start.
- ismfhi  in  1  read select; 1 = HI, 0 = LO.
- busy  out  1  high in DIVIDE and FIXUP.
- done  out  1  one-cycle pulse; HI/LO are valid from this cycle.
- div_zero  out  1  sticky flag: the last division had divisor == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_out  out  WIDTH  combinational: ismfhi ? hi : lo.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; hi = lo = 0; busy = done = div_zero = 0; internal remainder, quotient and counter = 0. An in-flight division is discarded and HI/LO are not written.
- States:
  - IDLE: wait for start.
  - DIVIDE: 32 iterations.
  - FIXUP: sign correction and HI/LO write.
  - DONE: one-cycle done pulse, then IDLE.
- IDLE, start == 1 at edge E0:
  - Latch sign_q = signed_op & (dividend[MSB] ^ divisor[MSB]) and sign_r = signed_op & dividend[MSB].
  - Load the magnitudes |dividend| and |divisor|. In unsigned mode load the raw values.
  - Remainder = 0, cnt = 0.
  - If divisor == 0, go to FIXUP directly. Otherwise go to DIVIDE.
- DIVIDE, one iteration per edge:
  - {rem, quo} shifted left by 1.
  - trial = rem_shifted - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial, quo[0] = 1.
  - cnt increments. Leave for FIXUP on the edge where cnt == WIDTH-1, so exactly WIDTH iterations run (edges E1..E32).
- FIXUP, one edge (E33):
  - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
  - div_zero = 0. Go to DONE.
- FIXUP with divisor == 0 (edge E1):
  - hi = dividend as latched; lo = all ones.
  - div_zero = 1. Go to DONE.
- DONE: done = 1 for exactly this cycle, then IDLE.
- Latency: a normal division has HI/LO updated and done high in the cycle after E33 (33 edges after the start edge). Divide-by-zero completes after 1 edge.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic modulo 2^WIDTH; no special path.
- start while busy or in DONE: ignored. Operands are not re-sampled and there is no error indication.
- start on the same cycle as reset: reset wins.
- hi/lo hold their value except on the FIXUP edge; mf_out may be read at any time, including while busy (returns the old value).
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).

Decomposition:
- Shared package cpu_pkg:
  - state enum div_state_t {IDLE, DIVIDE, FIXUP, DONE};
  - constant DIV_FUNC = 6'h1A;
  - constant MFHI_FUNC = 6'h10.
- One natural sub-module: div_step, a combinational single iteration. It takes rem, quo and divisor_mag and returns the next rem and quo. It is reusable if a radix-4 variant is built later.
- Control FSM, counter, sign handling and the HI/LO registers stay in hilo_div_unit.

Test Plan:
- divu 100 / 7: start=1, signed_op=0 → done 33 edges later; lo=14, hi=2; busy high for exactly 33 cycles; div_zero=0.
- div -7 / 2 (0xFFFFFFF9 / 2), signed_op=1 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then ismfhi=0 → mf_out=0xFFFFFFFD; ismfhi=1 → mf_out=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF signed → lo=0x80000000, hi=0. Then divu 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- div 1234 / 0 → done after 1 edge; hi=1234, lo=0xFFFFFFFF, div_zero=1. A following divu 9/3 → lo=3, hi=0, div_zero=0.
- Start 100/7 and pulse start with 50/5 at cycle 10 → second start ignored; result lo=14, hi=2; done pulses once.
- Preload hi=2/lo=14, start 1000/3, assert reset at cycle 15 → immediately busy=0, done=0, hi=lo=0, state IDLE. A new start 9/2 afterwards → lo=4, hi=1.
